mem_block_arbiter: RTL



---
 rtl/mem_block_arbiter_if.sv | 61 ++++++
 rtl/mem_block_arbiter.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/mem_block_arbiter_if.sv
// Bundles the cache-side request/response signals and the shared memory port
// of mem_block_arbiter.
//
// Modports:
//   master - the arbiter. It samples requests and memory read data. It drives
//            the read returns, the done pulses and every memory-port output.
//   slave  - the requesters plus the memory model (the opposite directions).
//
// Signals:
//   i_req/i_addr            I-side block read request (level) and address
//   i_rdata/i_rvalid/i_done I-side returned word, word strobe, block-complete pulse
//   d_req/d_we/d_addr       D-side request, write enable and address
//   d_wdata                 D-side write word for the current word_idx
//   d_rdata/d_rvalid/d_done D-side returned word, word strobe, block-complete pulse
//   word_idx                index of the word being accessed
//   mem_*                   shared memory port
interface mem_block_arbiter_if #(
  parameter int unsigned WORD_SIZE = 16
);
  logic                 i_req;
  logic [WORD_SIZE-1:0] i_addr;
  logic [WORD_SIZE-1:0] i_rdata;
  logic                 i_rvalid;
  logic                 i_done;

  logic                 d_req;
  logic                 d_we;
  logic [WORD_SIZE-1:0] d_addr;
  logic [WORD_SIZE-1:0] d_wdata;
  logic [WORD_SIZE-1:0] d_rdata;
  logic                 d_rvalid;
  logic                 d_done;

  logic [1:0]           word_idx;

  logic                 mem_read;
  logic                 mem_write;
  logic [WORD_SIZE-1:0] mem_addr;
  logic [WORD_SIZE-1:0] mem_wdata;
  logic [WORD_SIZE-1:0] mem_rdata;

  modport master (
    input  i_req, i_addr,
    output i_rdata, i_rvalid, i_done,
    input  d_req, d_we, d_addr, d_wdata,
    output d_rdata, d_rvalid, d_done,
    output word_idx,
    output mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    output i_req, i_addr,
    input  i_rdata, i_rvalid, i_done,
    output d_req, d_we, d_addr, d_wdata,
    input  d_rdata, d_rvalid, d_done,
    input  word_idx,
    input  mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_block_arbiter.sv
// Shares one memory port between the I-cache miss path and the D-cache
// miss/writeback path. Each grant moves a 4-word block. An I grant is always
// four reads. A D grant is four reads or four writes, chosen by d_we. Each word
// holds the port for LATENCY cycles.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high; clears all state and outputs
//   bus    mem_block_arbiter_if.master (requests, read returns, done pulses,
//          memory port)
//
// Parameters:
//   LATENCY    cycles each word access holds the memory port (>= 1)
//   WORD_SIZE  data/address width
module mem_block_arbiter #(
  parameter int unsigned LATENCY   = 2,
  parameter int unsigned WORD_SIZE = 16
) (
  input logic                clk,
  input logic                reset,
  mem_block_arbiter_if.master bus
);

  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(LATENCY - 1);
  // Clears the word offset so every block starts on a 4-word boundary.
  localparam logic [WORD_SIZE-1:0] BlockMask = ~WORD_SIZE'(3);

  localparam logic SideI = 1'b0;
  localparam logic SideD = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e               state_q, state_d;
  logic                 rr_q, rr_d;        // side served last; ties go to the other
  logic                 owner_q, owner_d;
  logic                 we_q, we_d;
  logic [WORD_SIZE-1:0] base_q, base_d;
  logic [1:0]           word_idx_q, word_idx_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [WORD_SIZE-1:0] wdata_q, wdata_d;
  logic [WORD_SIZE-1:0] i_rdata_q, i_rdata_d;
  logic [WORD_SIZE-1:0] d_rdata_q, d_rdata_d;
  logic                 i_rvalid_q, i_rvalid_d;
  logic                 d_rvalid_q, d_rvalid_d;
  logic                 grant_d;
  logic                 access;
  logic                 first_cycle;
  logic                 last_cycle;

  assign access      = (state_q == StAccess);
  assign first_cycle = (cnt_q == '0);
  assign last_cycle  = (cnt_q == CntLast);

  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    owner_d    = owner_q;
    we_d       = we_q;
    base_d     = base_q;
    word_idx_d = word_idx_q;
    cnt_d      = cnt_q;
    wdata_d    = wdata_q;
    i_rdata_d  = i_rdata_q;
    d_rdata_d  = d_rdata_q;
    i_rvalid_d = 1'b0;
    d_rvalid_d = 1'b0;
    grant_d    = SideI;

    unique case (state_q)
      StIdle: begin
        if (bus.i_req || bus.d_req) begin
          // D wins when it is alone, or on a tie when I was served last.
          grant_d    = bus.d_req && (!bus.i_req || (rr_q == SideI));
          owner_d    = grant_d;
          we_d       = (grant_d == SideD) && bus.d_we;
          base_d     = ((grant_d == SideD) ? bus.d_addr : bus.i_addr) & BlockMask;
          word_idx_d = 2'd0;
          cnt_d      = '0;
          state_d    = StAccess;
        end
      end

      StAccess: begin
        // Write data is live on the first cycle of a word, then held from
        // this register for the rest of the word.
        if (we_q && first_cycle) begin
          wdata_d = bus.d_wdata;
        end
        if (last_cycle) begin
          cnt_d      = '0;
          word_idx_d = word_idx_q + 2'd1;
          if (!we_q) begin
            if (owner_q == SideD) begin
              d_rdata_d  = bus.mem_rdata;
              d_rvalid_d = 1'b1;
            end else begin
              i_rdata_d  = bus.mem_rdata;
              i_rvalid_d = 1'b1;
            end
          end
          if (word_idx_q == 2'd3) begin
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end

      StDone: begin
        rr_d    = owner_q;
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      rr_q       <= SideI;
      owner_q    <= SideI;
      we_q       <= 1'b0;
      base_q     <= '0;
      word_idx_q <= 2'd0;
      cnt_q      <= '0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
      i_rvalid_q <= 1'b0;
      d_rvalid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      base_q     <= base_d;
      word_idx_q <= word_idx_d;
      cnt_q      <= cnt_d;
      wdata_q    <= wdata_d;
      i_rdata_q  <= i_rdata_d;
      d_rdata_q  <= d_rdata_d;
      i_rvalid_q <= i_rvalid_d;
      d_rvalid_q <= d_rvalid_d;
    end
  end

  // The memory port is quiet outside ACCESS. The block base is 4-aligned, so
  // base + word_idx never carries out of the block.
  assign bus.mem_read  = access && !we_q;
  assign bus.mem_write = access && we_q;
  assign bus.mem_addr  = access ? (base_q + WORD_SIZE'(word_idx_q)) : '0;
  assign bus.mem_wdata = (access && we_q) ? (first_cycle ? bus.d_wdata : wdata_q) : '0;
  assign bus.word_idx  = access ? word_idx_q : 2'd0;

  assign bus.i_rdata  = i_rdata_q;
  assign bus.i_rvalid = i_rvalid_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.d_rvalid = d_rvalid_q;
  assign bus.i_done   = (state_q == StDone) && (owner_q == SideI);
  assign bus.d_done   = (state_q == StDone) && (owner_q == SideD);

endmodule
